// File: rtl/prog_run_ctrl.sv
// Run controller and program counter: selects a program at Start, sequences fetch with
// branches, gates execution, acknowledges halt and aborts runaway programs via watchdog.
module prog_run_ctrl #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned NPROG = 4,
  parameter int unsigned SEL_W = (NPROG > 1) ? $clog2(NPROG) : 1,
  parameter logic [NPROG*PC_W-1:0] START_ADDR = {10'd768, 10'd512, 10'd256, 10'd0},
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [SEL_W-1:0] ProgSel,
  input  logic             HaltInst,
  input  logic             Branch,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             RunEn,
  output logic             Ack,
  output logic             TimedOut,
  output logic [CNT_W-1:0] CycleCount,
  output logic [SEL_W-1:0] ActiveProg
);

  typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             ack_q, ack_d;
  logic             to_q, to_d;
  logic [SEL_W-1:0] ap_q, ap_d;
  logic [SEL_W-1:0] sel_res;
  logic [PC_W-1:0]  entry_pc;
  logic             tmo_hit;

  always_comb begin
    // Out-of-range selects fall back to program 0
    sel_res  = (32'(ProgSel) < NPROG) ? ProgSel : '0;
    entry_pc = START_ADDR[32'(sel_res) * PC_W +: PC_W];
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    tmo_hit  = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    to_d    = to_q;
    ap_d    = ap_q;
    unique case (state_q)
      StIdle: begin
        if (Start) state_d = StArmed;
      end
      StArmed: begin
        ack_d = 1'b0;
        if (Start) begin
          pc_d  = entry_pc;
          ap_d  = sel_res;
          cnt_d = '0;
          to_d  = 1'b0;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        if (Start) begin
          state_d = StArmed;
        end else if (HaltInst) begin
          state_d = StDone;
          ack_d   = 1'b1;
        end else if (tmo_hit) begin
          state_d = StDone;
          ack_d   = 1'b1;
          to_d    = 1'b1;
        end else if (Branch) begin
          pc_d = Target;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      StDone: begin
        if (Start) state_d = StArmed;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      to_q    <= 1'b0;
      ap_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      to_q    <= to_d;
      ap_q    <= ap_d;
    end
  end

  assign ProgCtr    = pc_q;
  assign RunEn      = (state_q == StRun);
  assign Ack        = ack_q;
  assign TimedOut   = to_q;
  assign CycleCount = cnt_q;
  assign ActiveProg = ap_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Drives two differently parametrised controllers with shared stimulus and compares every
// output each cycle against a per-instance behavioural model, plus directed scenarios.
module tb_prog_run_ctrl;

  localparam logic [39:0] ADDR_A = {10'd768, 10'd512, 10'd256, 10'd0};
  localparam logic [29:0] ADDR_B = {10'd600, 10'd300, 10'd100};

  localparam int PH_IDLE  = 0;
  localparam int PH_ARMED = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       halt = 1'b0;
  logic       branch = 1'b0;
  logic [9:0] target = 10'd0;

  logic [9:0]  a_pc, b_pc;
  logic        a_run, b_run, a_ack, b_ack, a_to, b_to;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;
  logic [1:0]  a_ap, b_ap;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prog_run_ctrl #(
    .PC_W(10), .NPROG(4), .START_ADDR(ADDR_A), .CNT_W(16), .TIMEOUT(8)
  ) dut_a (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .ProgSel(sel), .HaltInst(halt),
    .Branch(branch), .Target(target), .ProgCtr(a_pc), .RunEn(a_run), .Ack(a_ack),
    .TimedOut(a_to), .CycleCount(a_cnt), .ActiveProg(a_ap)
  );

  prog_run_ctrl #(
    .PC_W(10), .NPROG(3), .START_ADDR(ADDR_B), .CNT_W(4), .TIMEOUT(0)
  ) dut_b (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .ProgSel(sel), .HaltInst(halt),
    .Branch(branch), .Target(target), .ProgCtr(b_pc), .RunEn(b_run), .Ack(b_ack),
    .TimedOut(b_to), .CycleCount(b_cnt), .ActiveProg(b_ap)
  );

  typedef struct {
    int ph;
    int pc;
    int cnt;
    int ack;
    int to;
    int ap;
  } mdl_t;

  mdl_t m[2];
  int nprog[2] = '{4, 3};
  int cmax[2]  = '{65535, 15};
  int tmo[2]   = '{8, 0};
  int tbl[2][4] = '{'{0, 256, 512, 768}, '{100, 300, 600, 0}};

  function automatic mdl_t model_reset();
    mdl_t r;
    r.ph = PH_IDLE; r.pc = 0; r.cnt = 0; r.ack = 0; r.to = 0; r.ap = 0;
    return r;
  endfunction

  function automatic mdl_t model_step(mdl_t s, int k);
    mdl_t n;
    int   r;
    n = s;
    case (s.ph)
      PH_IDLE: if (start) n.ph = PH_ARMED;
      PH_ARMED: begin
        n.ack = 0;
        if (start) begin
          r = (int'(sel) < nprog[k]) ? int'(sel) : 0;
          n.pc = tbl[k][r]; n.ap = r; n.cnt = 0; n.to = 0;
        end else begin
          n.ph = PH_RUN;
        end
      end
      PH_RUN: begin
        n.cnt = (s.cnt < cmax[k]) ? s.cnt + 1 : s.cnt;
        if (start) n.ph = PH_ARMED;
        else if (halt) begin
          n.ph = PH_DONE; n.ack = 1;
        end else if (tmo[k] != 0 && s.cnt + 1 == tmo[k]) begin
          n.ph = PH_DONE; n.ack = 1; n.to = 1;
        end else if (branch) n.pc = int'(target);
        else n.pc = (s.pc + 1) % 1024;
      end
      default: if (start) n.ph = PH_ARMED;
    endcase
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_eq("a.pc",  32'(a_pc),  m[0].pc);
    check_eq("a.run", 32'(a_run), (m[0].ph == PH_RUN) ? 1 : 0);
    check_eq("a.ack", 32'(a_ack), m[0].ack);
    check_eq("a.to",  32'(a_to),  m[0].to);
    check_eq("a.cnt", 32'(a_cnt), m[0].cnt);
    check_eq("a.ap",  32'(a_ap),  m[0].ap);
    check_eq("b.pc",  32'(b_pc),  m[1].pc);
    check_eq("b.run", 32'(b_run), (m[1].ph == PH_RUN) ? 1 : 0);
    check_eq("b.ack", 32'(b_ack), m[1].ack);
    check_eq("b.to",  32'(b_to),  m[1].to);
    check_eq("b.cnt", 32'(b_cnt), m[1].cnt);
    check_eq("b.ap",  32'(b_ap),  m[1].ap);
  endtask

  // Called at a negedge; applies inputs across one posedge and returns at the next negedge.
  task automatic tick(input logic st, input logic [1:0] sl, input logic h, input logic b,
                      input logic [9:0] t);
    start = st; sel = sl; halt = h; branch = b; target = t;
    @(posedge clk);
    m[0] = model_step(m[0], 0);
    m[1] = model_step(m[1], 1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    start = 1'b0; halt = 1'b0; branch = 1'b0;
    rst_n = 1'b0;
    #1;
    m[0] = model_reset();
    m[1] = model_reset();
    compare_all();
    check_eq("rst.pc0", 32'(a_pc), 0);
    check_eq("rst.run0", 32'(a_run), 0);
    check_eq("rst.ack0", 32'(a_ack), 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    m[0] = model_step(m[0], 0);
    m[1] = model_step(m[1], 1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic arm(input logic [1:0] sl, input int n);
    for (int i = 0; i < n; i++) tick(1'b1, sl, 1'b0, 1'b0, 10'd0);
    tick(1'b0, sl, 1'b0, 1'b0, 10'd0);
  endtask

  initial begin
    int  left;
    logic lvl;
    m[0] = model_reset();
    m[1] = model_reset();
    @(negedge clk);
    do_reset();

    // Program 2 runs 512..516 and halts on its 5th RUN cycle
    arm(2'd2, 3);
    check_eq("t2.entry", 32'(a_pc), 512);
    for (int i = 0; i < 4; i++) tick(1'b0, 2'd2, 1'b0, 1'b0, 10'd0);
    tick(1'b0, 2'd2, 1'b1, 1'b0, 10'd0);
    check_eq("t2.pc", 32'(a_pc), 516);
    check_eq("t2.ack", 32'(a_ack), 1);
    check_eq("t2.cnt", 32'(a_cnt), 5);
    check_eq("t2.ap", 32'(a_ap), 2);
    tick(1'b0, 2'd0, 1'b0, 1'b0, 10'd0);
    check_eq("t2.hold", 32'(a_pc), 516);

    // Branch to top of address space, then wrap
    arm(2'd1, 2);
    check_eq("t3.entry", 32'(a_pc), 256);
    tick(1'b0, 2'd1, 1'b0, 1'b1, 10'd1023);
    check_eq("t3.br", 32'(a_pc), 1023);
    tick(1'b0, 2'd1, 1'b0, 1'b0, 10'd0);
    check_eq("t3.wrap", 32'(a_pc), 0);
    tick(1'b0, 2'd1, 1'b0, 1'b0, 10'd0);
    check_eq("t3.next", 32'(a_pc), 1);
    tick(1'b0, 2'd1, 1'b1, 1'b0, 10'd0);

    // Watchdog expiry, then halt coinciding with expiry
    arm(2'd0, 2);
    for (int i = 0; i < 7; i++) tick(1'b0, 2'd0, 1'b0, 1'b0, 10'd0);
    check_eq("t4.early", 32'(a_ack), 0);
    tick(1'b0, 2'd0, 1'b0, 1'b0, 10'd0);
    check_eq("t4.ack", 32'(a_ack), 1);
    check_eq("t4.to", 32'(a_to), 1);
    check_eq("t4.cnt", 32'(a_cnt), 8);
    arm(2'd0, 2);
    for (int i = 0; i < 7; i++) tick(1'b0, 2'd0, 1'b0, 1'b0, 10'd0);
    tick(1'b0, 2'd0, 1'b1, 1'b0, 10'd0);
    check_eq("t4b.ack", 32'(a_ack), 1);
    check_eq("t4b.to", 32'(a_to), 0);
    check_eq("t4b.cnt", 32'(a_cnt), 8);

    // Abort by Start during RUN restarts program 1 without Ack
    arm(2'd0, 2);
    tick(1'b0, 2'd0, 1'b0, 1'b0, 10'd0);
    tick(1'b0, 2'd0, 1'b0, 1'b0, 10'd0);
    tick(1'b1, 2'd1, 1'b0, 1'b0, 10'd0);
    check_eq("t5.noack", 32'(a_ack), 0);
    tick(1'b1, 2'd1, 1'b0, 1'b0, 10'd0);
    tick(1'b0, 2'd1, 1'b0, 1'b0, 10'd0);
    check_eq("t5.pc", 32'(a_pc), 256);
    check_eq("t5.cnt", 32'(a_cnt), 0);
    check_eq("t5.ack", 32'(a_ack), 0);

    // Out-of-range select and counter saturation on the 3-program instance
    arm(2'd3, 2);
    check_eq("t6.entry", 32'(b_pc), 100);
    check_eq("t6.ap", 32'(b_ap), 0);
    for (int i = 0; i < 20; i++) tick(1'b0, 2'd3, 1'b0, 1'b0, 10'd0);
    check_eq("t6.sat", 32'(b_cnt), 15);
    check_eq("t6.run", 32'(b_run), 1);
    check_eq("t6.pc", 32'(b_pc), 120);

    // Asynchronous reset mid-RUN at PC 37
    tick(1'b0, 2'd0, 1'b0, 1'b1, 10'd37);
    check_eq("t1.pc37", 32'(b_pc), 37);
    do_reset();

    // Randomised traffic with level-held Start pulses and occasional resets
    lvl = 1'b0;
    left = 3;
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        lvl = ~lvl;
        left = lvl ? int'($urandom_range(2, 4)) : int'($urandom_range(1, 25));
      end
      left--;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        lvl = 1'b0;
        left = 2;
      end else begin
        tick(lvl, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 4) == 0), 10'($urandom_range(0, 1023)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
Parametrised run controller and program counter for the processor core, replacing the fixed single-program PC and Start/Ack glue.
- Selects one of NPROG programs at Start and loads that program's entry address.
- Sequences fetch with branch support and gates execution (RunEn).
- Raises a registered Ack at halt.
- Counts cycles, and can abort a runaway program through a watchdog timeout.

Parameters:
PC_W, 10, program counter / instruction address width
NPROG, 4, number of selectable programs (>=1)
SEL_W, $clog2(NPROG) (min 1), width of ProgSel
START_ADDR, {10'd768,10'd512,10'd256,10'd0}, flattened NPROG*PC_W entry-address table; entry k is at bits [k*PC_W +: PC_W]
CNT_W, 16, width of the cycle counter
TIMEOUT, 0, watchdog limit in RUN cycles; 0 disables the watchdog

Ports:
Clk  in  1  clock; all state updates on posedge
Reset_n  in  1  asynchronous, active-low reset
Start  in  1  start request; level-held by the testbench, a falling edge launches the run
ProgSel  in  SEL_W  program select, sampled while Start is high
HaltInst  in  1  decoder "done" for the current instruction
Branch  in  1  decoder: take Target this cycle
Target  in  PC_W  absolute branch target
ProgCtr  out  PC_W  instruction fetch address
RunEn  out  1  high only in RUN; the core forces NOP when low
Ack  out  1  program finished (normally or by timeout)
TimedOut  out  1  the last run ended by the watchdog
CycleCount  out  CNT_W  RUN cycles of the current/last run, including the halt cycle
ActiveProg  out  SEL_W  program index latched at launch

Behaviour:
- States: IDLE, ARMED, RUN, DONE.
- Reset (Reset_n=0, asynchronous, any state, including mid-run):
  - State goes to IDLE.
  - ProgCtr=0, RunEn=0, Ack=0, TimedOut=0, CycleCount=0, ActiveProg=0.
- IDLE:
  - Start=1 -> ARMED.
  - Otherwise all outputs hold.
- ARMED (every cycle while Start=1):
  - ProgCtr <= START_ADDR[ProgSel]; if ProgSel >= NPROG, use entry 0.
  - ActiveProg <= the same resolved index (last sampled value wins).
  - CycleCount <= 0, TimedOut <= 0, Ack <= 0.
  - Start=0 -> RUN.
- RUN:
  - RunEn=1 (combinational from state).
  - Each cycle: CycleCount <= CycleCount+1, saturating at all-ones (no wrap).
  - PC update priority:
    1. Start=1: abort -> ARMED. The PC reload follows ARMED rules from the next cycle. Ack is not raised.
    2. HaltInst=1: -> DONE. ProgCtr holds; Branch is ignored.
    3. TIMEOUT!=0 and CycleCount+1 == TIMEOUT: -> DONE, TimedOut <= 1.
    4. Branch=1: ProgCtr <= Target.
    5. Otherwise: ProgCtr <= ProgCtr+1, wrapping modulo 2^PC_W.
  - Latency: a halt sampled at edge N gives Ack=1 from just after edge N.
- DONE:
  - Ack=1 (registered), RunEn=0.
  - ProgCtr, CycleCount, TimedOut and ActiveProg hold.
  - Start=1 -> ARMED; Ack drops one edge later.
- HaltInst and Branch are ignored outside RUN.
- Simultaneous HaltInst and timeout on the same edge: halt wins, TimedOut=0.
- CycleCount saturation does not itself end the run.
- NPROG=1: ProgSel is a 1-bit port and is ignored.

Test Plan:
1. Reset_n low mid-RUN with ProgCtr=37 -> ProgCtr=0, RunEn=0, Ack=0 immediately, without waiting for a clock edge.
2. ProgSel=2, Start high 3 cycles then low; no Branch; HaltInst on the 5th RUN cycle -> ProgCtr runs 512..516, holds 516; Ack=1 from the next edge; CycleCount=5, ActiveProg=2.
3. In RUN at PC=256, Branch=1 with Target=1023, then run two more cycles -> ProgCtr 1023, then 0 (wrap), then 1.
4. TIMEOUT=8, program never halts -> after exactly 8 RUN cycles: Ack=1, TimedOut=1, CycleCount=8. A second variant asserts HaltInst on cycle 8 -> TimedOut=0.
5. Start reasserted during RUN at cycle 3 with ProgSel=1 -> no Ack; after Start falls, ProgCtr=256 and CycleCount restarts from 0.
6. NPROG=3, ProgSel=3 -> entry 0 used. CNT_W=4, no TIMEOUT, 20 RUN cycles -> CycleCount=15 (saturated), run continues.
